// File: rtl/anim_pkg.sv
// Shared definitions for the LED animation path: frame width, last frame
// index, play-mode encodings and the sequencer state enum. Imported by the
// frame sequencer, the decoder bank and the push-button front end.
package anim_pkg;

    localparam int FRAME_W = 5;
    localparam logic [FRAME_W-1:0] FRAME_LAST = 5'd31;

    typedef enum logic [1:0] {
        MODE_ONCE = 2'd0,
        MODE_LOOP = 2'd1,
        MODE_PING = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/anim_tick_gen.sv
// Prescaler for the frame sequencer. Counts enabled cycles and emits a
// one-cycle tick when the count reaches period-1, then restarts from 0.
// Ports:
//   clk    in  1      system clock (rising edge)
//   rst_n  in  1      asynchronous active-low reset
//   clr    in  1      synchronous clear of the prescaler (wins over en)
//   en     in  1      count enable; when low the prescaler holds its value
//   period in  PRE_W  step period in cycles (>= 2)
//   tick   out 1      high in the cycle whose closing edge completes a period
module anim_tick_gen #(
    parameter int PRE_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] period,
    output logic             tick
);

    logic [PRE_W-1:0] r_cnt;
    logic             w_match;

    assign w_match = (r_cnt == period - PRE_W'(1));
    // A clear in the same cycle suppresses the tick so a restart never steps.
    assign tick    = en && !clr && w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_match) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/anim_frame_seq.sv
// Frame sequencer for the LED animation path. Produces the 5-bit frame index
// shared by all 7-segment pattern decoders, stepping once per period in
// one-shot, loop or ping-pong order.
// Ports:
//   clk    in  1  system clock (rising edge)
//   rst_n  in  1  asynchronous active-low reset
//   start  in  1  pulse: latch mode/spd and (re)start from frame 0
//   stop   in  1  pulse: abort to idle, frame 0
//   pause  in  1  pulse: toggle RUN <-> PAUSE
//   mode   in  2  0 once, 1 loop, 2 ping-pong, 3 behaves as loop
//   spd    in  2  step period = BASE_DIV << spd cycles
//   frame  out 5  current frame index (registered)
//   step   out 1  pulse after frame advanced on a tick
//   busy   out 1  high in RUN and PAUSE
//   done   out 1  pulse on entry to DONE (once mode)
module anim_frame_seq
    import anim_pkg::*;
#(
    parameter int BASE_DIV = 12_500_000,
    parameter int PRE_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [1:0]         spd,
    output logic [FRAME_W-1:0] frame,
    output logic               step,
    output logic               busy,
    output logic               done
);

    state_e             r_state;
    state_e             w_state_nxt;
    mode_e              r_mode;
    mode_e              w_mode_nxt;
    logic [1:0]         r_spd;
    logic [1:0]         w_spd_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic               r_dir_up;
    logic               w_dir_up_nxt;
    logic               r_step;
    logic               w_step_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic               w_clr;
    logic               w_en;
    logic               w_tick;
    logic [PRE_W-1:0]   w_period;

    assign w_period = PRE_W'(BASE_DIV) << r_spd;
    assign w_en     = (r_state == ST_RUN);

    anim_tick_gen #(
        .PRE_W (PRE_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .en     (w_en),
        .period (w_period),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_ONCE;
            r_spd    <= 2'd0;
            r_frame  <= '0;
            r_dir_up <= 1'b1;
            r_step   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_spd    <= w_spd_nxt;
            r_frame  <= w_frame_nxt;
            r_dir_up <= w_dir_up_nxt;
            r_step   <= w_step_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_spd_nxt    = r_spd;
        w_frame_nxt  = r_frame;
        w_dir_up_nxt = r_dir_up;
        w_step_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_clr        = 1'b0;

        if (stop) begin
            w_state_nxt  = ST_IDLE;
            w_frame_nxt  = '0;
            w_dir_up_nxt = 1'b1;
            w_clr        = 1'b1;
        end else if (start) begin
            w_state_nxt  = ST_RUN;
            w_mode_nxt   = mode_e'(mode);
            w_spd_nxt    = spd;
            w_frame_nxt  = '0;
            w_dir_up_nxt = 1'b1;
            w_clr        = 1'b1;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end
                    // A tick landing on the pause edge still completes its
                    // step; finishing in once mode overrides the pause.
                    if (w_tick) begin
                        unique case (r_mode)
                            MODE_ONCE: begin
                                if (r_frame == FRAME_LAST) begin
                                    w_state_nxt = ST_DONE;
                                    w_done_nxt  = 1'b1;
                                end else begin
                                    w_frame_nxt = r_frame + 5'd1;
                                    w_step_nxt  = 1'b1;
                                end
                            end
                            MODE_PING: begin
                                w_step_nxt = 1'b1;
                                if (r_dir_up) begin
                                    if (r_frame == FRAME_LAST) begin
                                        w_dir_up_nxt = 1'b0;
                                        w_frame_nxt  = FRAME_LAST - 5'd1;
                                    end else begin
                                        w_frame_nxt = r_frame + 5'd1;
                                    end
                                end else begin
                                    if (r_frame == '0) begin
                                        w_dir_up_nxt = 1'b1;
                                        w_frame_nxt  = 5'd1;
                                    end else begin
                                        w_frame_nxt = r_frame - 5'd1;
                                    end
                                end
                            end
                            default: begin
                                // Loop and the reserved encoding: 5-bit wrap 31 -> 0.
                                w_frame_nxt = r_frame + 5'd1;
                                w_step_nxt  = 1'b1;
                            end
                        endcase
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    // IDLE and DONE only leave on start/stop.
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
    end

    assign frame = r_frame;
    assign step  = r_step;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
